// File: rtl/led_share_pkg.sv
// Shared types and constants for the LED sharing scheduler.
// Active-low colour encoding: a 0 bit lights that LED die.
package led_share_pkg;

  // Scheduler states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_GAP   = 2'd2
  } led_state_e;

  // Idle rotation phase, kept across service periods
  typedef enum logic [1:0] {
    ROT_G = 2'd0,
    ROT_R = 2'd1,
    ROT_B = 2'd2
  } rot_phase_e;

  localparam logic [2:0] LED_G   = 3'b110;
  localparam logic [2:0] LED_R   = 3'b101;
  localparam logic [2:0] LED_B   = 3'b011;
  localparam logic [2:0] LED_OFF = 3'b111;

  // Next step of the idle G->R->B rotation
  function automatic rot_phase_e rot_next(input rot_phase_e ph);
    case (ph)
      ROT_G:   rot_next = ROT_R;
      ROT_R:   rot_next = ROT_B;
      ROT_B:   rot_next = ROT_G;
      default: rot_next = ROT_G;
    endcase
  endfunction

  // LED drive for a rotation phase
  function automatic logic [2:0] rot_color(input rot_phase_e ph);
    case (ph)
      ROT_G:   rot_color = LED_G;
      ROT_R:   rot_color = LED_R;
      ROT_B:   rot_color = LED_B;
      default: rot_color = LED_G;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Tick prescaler: counts 0..TICK_DIV-1 and pulses tick for one cycle on the
// last count. restart forces the count back to 0 so every scheduler phase
// starts on a whole tick boundary.
module led_tick_gen #(
  parameter int TICK_DIV = 2_400_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic restart,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_r;

  assign tick = (presc_r == PRESC_LAST);

  // Prescaler count with wrap on terminal count and restart on phase entry
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      presc_r <= '0;
    end else if (restart) begin
      presc_r <= '0;
    end else if (tick) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

endmodule

// File: rtl/led_share_sched.sv
// Round-robin scheduler sharing one active-low RGB LED between N_REQ
// status requesters. Each grant is shown for HOLD_TICKS ticks, grants are
// separated by GAP_TICKS ticks of LED-off, and with nothing pending the LED
// runs the idle G->R->B rotation (phase kept while serving).
// Optional feature: define LED_SHARE_BLINK_EN to let a requester ask for its
// colour to blink (toggle every tick) while it is served.
module led_share_sched
  import led_share_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int TICK_DIV   = 2_400_000,
  parameter int HOLD_TICKS = 10,
  parameter int GAP_TICKS  = 1,
  parameter int IDLE_TICKS = 10
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [3*N_REQ-1:0]   req_color,
  input  logic [N_REQ-1:0]     req_blink,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic [2:0]           led
);

  localparam int IW = $clog2(N_REQ);
  localparam int MAX_TICKS = (HOLD_TICKS > GAP_TICKS)
                           ? ((HOLD_TICKS > IDLE_TICKS) ? HOLD_TICKS : IDLE_TICKS)
                           : ((GAP_TICKS > IDLE_TICKS) ? GAP_TICKS : IDLE_TICKS);
  localparam int TW = $clog2(MAX_TICKS + 1);

  localparam logic [TW-1:0]    HOLD_LAST = TW'(HOLD_TICKS - 1);
  localparam logic [TW-1:0]    GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0]    IDLE_LAST = TW'(IDLE_TICKS - 1);
  localparam logic [IW-1:0]    LAST_IDX  = IW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

  // First high request at or after ptr, searching upward with wrap
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [IW-1:0]    ptr);
    logic found;
    int   j;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!found && r[j]) begin
        rr_pick = IW'(j);
        found   = 1'b1;
      end
    end
  endfunction

  led_state_e     state_r;
  led_state_e     state_nxt_s;
  logic           restart_s;
  logic           tick_s;
  logic           last_s;
  logic           load_grant_s;
  logic           idle_step_s;
  logic           any_req_s;
  logic           others_s;
  logic           own_s;
  logic [IW-1:0]  pick_idx_s;
  logic [TW-1:0]  tick_cnt_r;
  logic [TW-1:0]  tick_last_s;

  logic [N_REQ-1:0] grant_r;
  logic [IW-1:0]    gidx_r;
  logic [IW-1:0]    rr_ptr_r;
  logic [2:0]       led_r;
  logic             busy_r;
  rot_phase_e       phase_r;

`ifdef LED_SHARE_BLINK_EN
  logic [2:0]       color_r;
  logic             blink_en_r;
  logic             blink_off_r;
`else
  logic             unused_blink_s;
  assign unused_blink_s = ^req_blink;
`endif

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .restart (restart_s),
    .tick    (tick_s)
  );

  assign any_req_s    = |req;
  assign others_s     = |(req & ~grant_r);
  assign own_s        = |(req & grant_r);
  assign pick_idx_s   = rr_pick(req, rr_ptr_r);
  assign last_s       = tick_s && (tick_cnt_r == tick_last_s);
  assign load_grant_s = restart_s && (state_nxt_s == S_SERVE);
  assign idle_step_s  = (state_r == S_IDLE) && last_s;

  // Terminal tick count of the current phase
  always_comb begin
    tick_last_s = IDLE_LAST;
    case (state_r)
      S_IDLE:  tick_last_s = IDLE_LAST;
      S_SERVE: tick_last_s = HOLD_LAST;
      S_GAP:   tick_last_s = GAP_LAST;
      default: tick_last_s = IDLE_LAST;
    endcase
  end

  // Ticks elapsed in the current phase; cleared on every phase entry
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tick_cnt_r <= '0;
    end else if (restart_s) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      if (tick_cnt_r == tick_last_s) begin
        tick_cnt_r <= '0;
      end else begin
        tick_cnt_r <= tick_cnt_r + TW'(1);
      end
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; restart marks a phase (re)entry that realigns the tick grid
  always_comb begin
    state_nxt_s = state_r;
    restart_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = S_SERVE;
          restart_s   = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SERVE: begin
        if (last_s) begin
          restart_s = 1'b1;
          // Sole remaining requester keeps the LED without a gap
          if (others_s || !own_s) begin
            state_nxt_s = S_GAP;
          end else begin
            state_nxt_s = S_SERVE;
          end
        end else begin
          state_nxt_s = S_SERVE;
        end
      end
      S_GAP: begin
        if (last_s) begin
          restart_s = 1'b1;
          if (any_req_s) begin
            state_nxt_s = S_SERVE;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end else begin
          state_nxt_s = S_GAP;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        restart_s   = 1'b1;
      end
    endcase
  end

  // Registered outputs, round-robin pointer and idle rotation phase.
  // Leaving IDLE takes priority over a rotation step due on the same edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      grant_r     <= '0;
      gidx_r      <= '0;
      rr_ptr_r    <= '0;
      led_r       <= LED_G;
      busy_r      <= 1'b0;
      phase_r     <= ROT_G;
`ifdef LED_SHARE_BLINK_EN
      color_r     <= LED_G;
      blink_en_r  <= 1'b0;
      blink_off_r <= 1'b0;
`endif
    end else begin
      busy_r <= (state_nxt_s != S_IDLE);
      if (load_grant_s) begin
        grant_r <= ONE_HOT0 << pick_idx_s;
        gidx_r  <= pick_idx_s;
        led_r   <= req_color[3*int'(pick_idx_s) +: 3];
`ifdef LED_SHARE_BLINK_EN
        color_r     <= req_color[3*int'(pick_idx_s) +: 3];
        blink_en_r  <= req_blink[pick_idx_s];
        blink_off_r <= 1'b0;
`endif
      end else if (state_nxt_s == S_GAP) begin
        grant_r <= '0;
        led_r   <= LED_OFF;
        if (state_r == S_SERVE) begin
          rr_ptr_r <= (gidx_r == LAST_IDX) ? '0 : (gidx_r + IW'(1));
        end
      end else if (state_nxt_s == S_IDLE) begin
        grant_r <= '0;
        if (idle_step_s) begin
          phase_r <= rot_next(phase_r);
          led_r   <= rot_color(rot_next(phase_r));
        end else begin
          led_r   <= rot_color(phase_r);
        end
      end else begin
        // Hold in progress: grant and latched colour stay put
`ifdef LED_SHARE_BLINK_EN
        if (tick_s && blink_en_r) begin
          blink_off_r <= ~blink_off_r;
          led_r       <= blink_off_r ? color_r : LED_OFF;
        end
`endif
      end
    end
  end

  assign grant = grant_r;
  assign busy  = busy_r;
  assign led   = led_r;

endmodule
